fetch_pc_seq: RTL

- PC sequencing stage that sits directly upstream of the 1-bit 2:1 select muxes in fetch.
- Holds the program counter and computes pc_plus2.
- Drives next_pc_sel, the per-bit mux select: 0 chooses pc_plus2, 1 chooses the redirect target.
- Manages stall, halt and redirect sequencing with a small FSM, and qualifies fetch with fetch_valid.

---
 rtl/wisc_fetch_pkg.sv | 15 +
 rtl/pc_reg.sv | 25 ++
 rtl/fetch_pc_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/wisc_fetch_pkg.sv
// Shared fetch definitions: word width, PC increment, reset PC and sequencer states.
package wisc_fetch_pkg;

    localparam int unsigned       WORD_W   = 16;
    localparam int unsigned       PC_INC   = 2;
    localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StHalt,
        StFlush
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// WIDTH-bit register with load enable and synchronous reset value.
module pc_reg #(
    parameter int unsigned       Width    = 16,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= ResetVal;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_pc_seq.sv
// Fetch PC sequencer: PC register, pc+inc, redirect select and run/stall/halt FSM.
// Define FETCH_REDIRECT_BUBBLE_EN to insert a one-cycle invalid FLUSH slot after redirects.
module fetch_pc_seq #(
    parameter int unsigned      WIDTH    = wisc_fetch_pkg::WORD_W,
    parameter logic [WIDTH-1:0] RESET_PC = wisc_fetch_pkg::RESET_PC,
    parameter int unsigned      PC_INC   = wisc_fetch_pkg::PC_INC
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_target_i,
    input  logic             halt_req_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus2_o,
    output logic             next_pc_sel_o,
    output logic             fetch_valid_o,
    output logic             halted_o,
    output logic             misalign_err_o
);

    import wisc_fetch_pkg::*;

`ifdef FETCH_REDIRECT_BUBBLE_EN
    localparam fetch_state_e RedirSt = StFlush;
`else
    localparam fetch_state_e RedirSt = StRun;
`endif

    fetch_state_e     state_q, state_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             halted_q, halted_d;
    logic             misalign_q, misalign_d;
    logic             pc_en;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] redirect_pc;

    pc_reg #(
        .Width    (WIDTH),
        .ResetVal (RESET_PC)
    ) u_pc_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (pc_en),
        .d_i   (pc_d),
        .q_o   (pc_o)
    );

    assign pc_plus2_o    = pc_o + WIDTH'(PC_INC);
    assign redirect_pc   = {redirect_target_i[WIDTH-1:1], 1'b0};
    assign next_pc_sel_o = redirect_i & ~halt_req_i & (state_q != StHalt) & ~rst_i;

    always_comb begin
        state_d = state_q;
        pc_en   = 1'b0;
        pc_d    = next_pc_sel_o ? redirect_pc : pc_plus2_o;
        unique case (state_q)
            StRun, StStall: begin
                if (halt_req_i) begin
                    state_d = StHalt;
                end else if (redirect_i) begin
                    pc_en   = 1'b1;
                    state_d = RedirSt;
                end else if (stall_i) begin
                    state_d = StStall;
                end else begin
                    pc_en   = 1'b1;
                    state_d = StRun;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
`ifdef FETCH_REDIRECT_BUBBLE_EN
            // Stall is not sampled here; the following RUN cycle picks it up.
            StFlush: begin
                if (halt_req_i) begin
                    state_d = StHalt;
                end else begin
                    pc_en   = 1'b1;
                    state_d = redirect_i ? StFlush : StRun;
                end
            end
`else
            default: begin
                state_d = StRun;
            end
`endif
        endcase

        fetch_valid_d = (state_d == StRun) || (state_d == StStall);
        halted_d      = (state_d == StHalt);
        misalign_d    = next_pc_sel_o & redirect_target_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StRun;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

    assign fetch_valid_o  = fetch_valid_q;
    assign halted_o       = halted_q;
    assign misalign_err_o = misalign_q;

endmodule
